// File: rtl/alarm_event_gen.sv
// Alarm/chime event source: hour strobe + chime count, alarm register, ring/snooze/stop FSM.
// Strobes 1 cycle after a clock_time change; optional quiet window via ALARM_QUIET_HOURS_EN.
module alarm_event_gen #(
  parameter int SNOOZE_MIN  = 5,
  parameter int RING_SEC    = 60,
  parameter int CHIME_12H   = 1,
  parameter int QUIET_START = 22,
  parameter int QUIET_END   = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] clock_time,
  input  logic        alarm_set,
  input  logic [15:0] alarm_time_in,
  input  logic        alarm_en,
  input  logic        snooze,
  input  logic        stop,
  output logic        on_the_hour,
  output logic        on_alarm,
  output logic [4:0]  chime_count,
  output logic [15:0] alarm_time,
  output logic        alarm_active,
  output logic        snoozing,
  output logic        set_err
);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  localparam logic [7:0]  RING_LOAD = 8'(RING_SEC);
  // 59 min * 60 s needs 12 bits, so the snooze counter is one bit wider than 11
  localparam logic [11:0] SNZ_LOAD  = 12'(SNOOZE_MIN * 60);

  state_t      state, state_nxt;
  logic [23:0] prev_time;
  logic        primed;
  logic [7:0]  ring_cnt, ring_cnt_nxt;
  logic [11:0] snz_cnt, snz_cnt_nxt;
  logic        on_alarm_nxt;

  logic        tick;
  logic        hour_evt;
  logic        alarm_match;
  logic        set_valid;
  logic        quiet;
  logic [4:0]  hour_bin;
  logic [4:0]  chime_val;

  assign tick        = primed && (clock_time != prev_time);
  assign hour_evt    = tick && (clock_time[15:0] == 16'h0000);
  assign alarm_match = (clock_time[23:8] == alarm_time) && (clock_time[7:0] == 8'h00);
  assign hour_bin    = {1'b0, clock_time[23:20]} * 5'd10 + {1'b0, clock_time[19:16]};

  assign set_valid = (alarm_time_in[15:12] <= 4'd2) && (alarm_time_in[11:8] <= 4'd9) &&
                     (alarm_time_in[7:4]   <= 4'd5) && (alarm_time_in[3:0]  <= 4'd9) &&
                     !((alarm_time_in[15:12] == 4'd2) && (alarm_time_in[11:8] > 4'd3));

  always_comb begin
    chime_val = hour_bin;
    if (CHIME_12H != 0) begin
      if (hour_bin == 5'd0)
        chime_val = 5'd12;
      else if (hour_bin > 5'd12)
        chime_val = hour_bin - 5'd12;
    end
  end

`ifdef ALARM_QUIET_HOURS_EN
  localparam logic [4:0] Q_START = 5'(QUIET_START);
  localparam logic [4:0] Q_END   = 5'(QUIET_END);

  always_comb begin
    if (Q_START > Q_END)
      quiet = (hour_bin >= Q_START) || (hour_bin < Q_END);
    else
      quiet = (hour_bin >= Q_START) && (hour_bin < Q_END);
  end
`else
  assign quiet = 1'b0;
`endif

  // Priority: alarm_en low > valid alarm_set > stop > snooze > tick-driven moves
  always_comb begin
    state_nxt    = state;
    ring_cnt_nxt = ring_cnt;
    snz_cnt_nxt  = snz_cnt;
    on_alarm_nxt = 1'b0;
    if (!alarm_en) begin
      state_nxt = IDLE;
    end else if (alarm_set && set_valid) begin
      state_nxt = IDLE;
    end else if (stop) begin
      state_nxt = IDLE;
    end else if (snooze && (state == RING)) begin
      state_nxt   = SNOOZE;
      snz_cnt_nxt = SNZ_LOAD;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (alarm_match) begin
            state_nxt    = RING;
            ring_cnt_nxt = RING_LOAD;
            on_alarm_nxt = 1'b1;
          end
        end
        RING: begin
          if (ring_cnt == 8'd1)
            state_nxt = IDLE;
          else
            ring_cnt_nxt = ring_cnt - 8'd1;
        end
        SNOOZE: begin
          if (snz_cnt == 12'd1) begin
            state_nxt    = RING;
            ring_cnt_nxt = RING_LOAD;
            on_alarm_nxt = 1'b1;
          end else begin
            snz_cnt_nxt = snz_cnt - 12'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_time    <= 24'h000000;
      primed       <= 1'b0;
      ring_cnt     <= 8'd0;
      snz_cnt      <= 12'd0;
      on_the_hour  <= 1'b0;
      on_alarm     <= 1'b0;
      chime_count  <= 5'd0;
      alarm_time   <= 16'h0000;
      alarm_active <= 1'b0;
      snoozing     <= 1'b0;
      set_err      <= 1'b0;
    end else begin
      prev_time    <= clock_time;
      primed       <= 1'b1;
      ring_cnt     <= ring_cnt_nxt;
      snz_cnt      <= snz_cnt_nxt;
      on_alarm     <= on_alarm_nxt;
      on_the_hour  <= hour_evt && !quiet;
      if (hour_evt)
        chime_count <= chime_val;
      set_err      <= alarm_set && !set_valid;
      if (alarm_set && set_valid)
        alarm_time <= alarm_time_in;
      alarm_active <= (state_nxt == RING);
      snoozing     <= (state_nxt == SNOOZE);
    end
  end

endmodule

// File: tb/tb_alarm_event_gen.sv
// Bench for alarm_event_gen: directed vector table, multi-cycle sequences, random run vs tick-count model.
module tb_alarm_event_gen;

  localparam int SNOOZE_MIN  = 5;
  localparam int RING_SEC    = 60;
  localparam int CHIME_12H   = 1;
  localparam int QUIET_START = 22;
  localparam int QUIET_END   = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] clock_time = '0;
  logic        alarm_set = 1'b0;
  logic [15:0] alarm_time_in = '0;
  logic        alarm_en = 1'b0;
  logic        snooze = 1'b0;
  logic        stop = 1'b0;
  logic        on_the_hour, on_alarm, alarm_active, snoozing, set_err;
  logic [4:0]  chime_count;
  logic [15:0] alarm_time;

  always #5 clk = ~clk;

  alarm_event_gen #(
    .SNOOZE_MIN(SNOOZE_MIN), .RING_SEC(RING_SEC), .CHIME_12H(CHIME_12H),
    .QUIET_START(QUIET_START), .QUIET_END(QUIET_END)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clock_time(clock_time), .alarm_set(alarm_set),
    .alarm_time_in(alarm_time_in), .alarm_en(alarm_en), .snooze(snooze), .stop(stop),
    .on_the_hour(on_the_hour), .on_alarm(on_alarm), .chime_count(chime_count),
    .alarm_time(alarm_time), .alarm_active(alarm_active), .snoozing(snoozing),
    .set_err(set_err)
  );

  int n_pass = 0;
  int n_total = 0;
  bit cmp_model = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int bcd_hour(input logic [23:0] t);
    return int'(t[23:20]) * 10 + int'(t[19:16]);
  endfunction

  function automatic int bcd2sec(input logic [23:0] t);
    return bcd_hour(t) * 3600 + (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 +
           int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction

  function automatic logic [23:0] sec2bcd(input int s);
    int h, m, x;
    s = ((s % 86400) + 86400) % 86400;
    h = s / 3600; m = (s / 60) % 60; x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic bit hhmm_valid(input logic [15:0] a);
    int d3, d2, d1, d0;
    d3 = int'(a[15:12]); d2 = int'(a[11:8]); d1 = int'(a[7:4]); d0 = int'(a[3:0]);
    return (d3 <= 9) && (d2 <= 9) && (d1 <= 9) && (d0 <= 9) &&
           (d3 * 10 + d2 <= 23) && (d1 * 10 + d0 <= 59);
  endfunction

  function automatic bit tb_quiet(input int h);
`ifdef ALARM_QUIET_HOURS_EN
    if (QUIET_START > QUIET_END) return (h >= QUIET_START) || (h < QUIET_END);
    return (h >= QUIET_START) && (h < QUIET_END);
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: ring/snooze expressed as deadlines on a running tick count
  int          m_prev, m_ticks, m_deadline, m_mode;
  bit          m_primed;
  logic [15:0] m_alarm;
  int          e_hour, e_al, e_chime, e_err;

  task automatic model_step();
    bit tick, valid;
    int h;
    if (!rst_n) begin
      m_prev = 0; m_primed = 0; m_ticks = 0; m_deadline = 0; m_mode = 0;
      m_alarm = 16'h0; e_hour = 0; e_al = 0; e_chime = 0; e_err = 0;
      return;
    end
    tick = m_primed && (int'(clock_time) != m_prev);
    if (tick) m_ticks++;
    e_hour = 0; e_al = 0; e_err = 0;
    valid = hhmm_valid(alarm_time_in);
    if (alarm_set) begin
      if (valid) m_alarm = alarm_time_in;
      else e_err = 1;
    end
    if (tick && clock_time[15:0] == 16'h0) begin
      h = bcd_hour(clock_time);
      e_chime = (CHIME_12H != 0) ? ((h % 12 == 0) ? 12 : h % 12) : h;
      e_hour = tb_quiet(h) ? 0 : 1;
    end
    if (!alarm_en || (alarm_set && valid) || stop) m_mode = 0;
    else if (snooze && m_mode == 1) begin
      m_mode = 2; m_deadline = m_ticks + SNOOZE_MIN * 60;
    end else if (tick) begin
      if (m_mode == 0) begin
        if (clock_time[23:8] == m_alarm && clock_time[7:0] == 8'h00) begin
          m_mode = 1; m_deadline = m_ticks + RING_SEC; e_al = 1;
        end
      end else if (m_ticks == m_deadline) begin
        if (m_mode == 1) m_mode = 0;
        else begin
          m_mode = 1; m_deadline = m_ticks + RING_SEC; e_al = 1;
        end
      end
    end
    m_prev = int'(clock_time);
    m_primed = 1;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    if (cmp_model) begin
      chk("on_the_hour", on_the_hour, e_hour);
      chk("on_alarm", on_alarm, e_al);
      chk("chime_count", chime_count, e_chime);
      chk("alarm_time", alarm_time, m_alarm);
      chk("alarm_active", alarm_active, m_mode == 1);
      chk("snoozing", snoozing, m_mode == 2);
      chk("set_err", set_err, e_err);
    end
  endtask

  task automatic step(input logic [23:0] ct, input bit aset, input logic [15:0] atin,
                      input bit snz, input bit stp);
    clock_time = ct; alarm_set = aset; alarm_time_in = atin; snooze = snz; stop = stp;
    cyc();
    alarm_set = 0; snooze = 0; stop = 0;
  endtask

  typedef struct {
    bit rst; logic [23:0] ct; bit aset; logic [15:0] atin; bit aen; bit snz; bit stp;
    bit hr; bit al; int ch; logic [15:0] ao; bit act; bit sz; bit err;
  } vec_t;

  vec_t vt[20];

  initial begin
    int cs, base, r;
    vt[0]  = '{0, 24'h000000, 0, 16'h0000, 0, 0, 0, 0, 0,  0, 16'h0000, 0, 0, 0};
    vt[1]  = '{0, 24'h000000, 0, 16'h0000, 0, 0, 0, 0, 0,  0, 16'h0000, 0, 0, 0};
    vt[2]  = '{1, 24'h000000, 0, 16'h0000, 0, 0, 0, 0, 0,  0, 16'h0000, 0, 0, 0};
    vt[3]  = '{1, 24'h000000, 0, 16'h0000, 0, 0, 0, 0, 0,  0, 16'h0000, 0, 0, 0};
    vt[4]  = '{1, 24'h010000, 0, 16'h0000, 0, 0, 0, 1, 0,  1, 16'h0000, 0, 0, 0};
    vt[5]  = '{1, 24'h010000, 0, 16'h0000, 0, 0, 0, 0, 0,  1, 16'h0000, 0, 0, 0};
    vt[6]  = '{1, 24'h130000, 0, 16'h0000, 0, 0, 0, 1, 0,  1, 16'h0000, 0, 0, 0};
    vt[7]  = '{1, 24'h130001, 0, 16'h0000, 0, 0, 0, 0, 0,  1, 16'h0000, 0, 0, 0};
    vt[8]  = '{1, 24'h000000, 0, 16'h0000, 0, 0, 0, 1, 0, 12, 16'h0000, 0, 0, 0};
    vt[9]  = '{1, 24'h000000, 1, 16'h0730, 1, 0, 0, 0, 0, 12, 16'h0730, 0, 0, 0};
    vt[10] = '{1, 24'h072959, 0, 16'h0000, 1, 0, 0, 0, 0, 12, 16'h0730, 0, 0, 0};
    vt[11] = '{1, 24'h073000, 0, 16'h0000, 1, 0, 0, 0, 1, 12, 16'h0730, 1, 0, 0};
    vt[12] = '{1, 24'h073000, 0, 16'h0000, 1, 0, 0, 0, 0, 12, 16'h0730, 1, 0, 0};
    vt[13] = '{1, 24'h073000, 1, 16'h2460, 1, 0, 0, 0, 0, 12, 16'h0730, 1, 0, 1};
    vt[14] = '{1, 24'h073001, 0, 16'h0000, 1, 1, 1, 0, 0, 12, 16'h0730, 0, 0, 0};
    vt[15] = '{1, 24'h073001, 1, 16'h0800, 1, 0, 0, 0, 0, 12, 16'h0800, 0, 0, 0};
    vt[16] = '{1, 24'h075959, 0, 16'h0000, 1, 0, 0, 0, 0, 12, 16'h0800, 0, 0, 0};
    vt[17] = '{1, 24'h080000, 0, 16'h0000, 1, 0, 0, 1, 1,  8, 16'h0800, 1, 0, 0};
    vt[18] = '{1, 24'h080000, 1, 16'h9999, 1, 0, 0, 0, 0,  8, 16'h0800, 1, 0, 1};
    vt[19] = '{1, 24'h080000, 0, 16'h0000, 0, 0, 0, 0, 0,  8, 16'h0800, 0, 0, 0};

    for (int i = 0; i < 20; i++) begin
      rst_n = vt[i].rst; clock_time = vt[i].ct; alarm_set = vt[i].aset;
      alarm_time_in = vt[i].atin; alarm_en = vt[i].aen; snooze = vt[i].snz; stop = vt[i].stp;
      cyc();
      chk($sformatf("v%0d_hour", i), on_the_hour,
          (vt[i].hr && !tb_quiet(bcd_hour(vt[i].ct))) ? 1 : 0);
      chk($sformatf("v%0d_alarm", i), on_alarm, vt[i].al);
      chk($sformatf("v%0d_chime", i), chime_count, vt[i].ch);
      chk($sformatf("v%0d_atime", i), alarm_time, vt[i].ao);
      chk($sformatf("v%0d_active", i), alarm_active, vt[i].act);
      chk($sformatf("v%0d_snoozing", i), snoozing, vt[i].sz);
      chk($sformatf("v%0d_err", i), set_err, vt[i].err);
    end
    alarm_set = 0; snooze = 0; stop = 0;

    // Auto-stop after RING_SEC ticks
    cmp_model = 1; alarm_en = 1;
    step(24'h080000, 1, 16'h0730, 0, 0);
    step(24'h072959, 0, 0, 0, 0);
    step(24'h073000, 0, 0, 0, 0);
    chk("ring_start", on_alarm, 1);
    base = bcd2sec(24'h073000);
    for (int k = 1; k <= RING_SEC; k++) begin
      step(sec2bcd(base + k), 0, 0, 0, 0);
      if (k == RING_SEC - 1) chk("ring_last_tick", alarm_active, 1);
      if (k == RING_SEC) chk("ring_autostop", alarm_active, 0);
    end

    // Snooze then re-ring exactly SNOOZE_MIN*60 ticks later
    step(24'h072959, 0, 0, 0, 0);
    step(24'h073000, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) step(sec2bcd(base + k), 0, 0, 0, 0);
    step(24'h073010, 0, 0, 1, 0);
    chk("snooze_flag", snoozing, 1);
    chk("snooze_not_active", alarm_active, 0);
    for (int k = 1; k <= SNOOZE_MIN * 60; k++) begin
      step(sec2bcd(base + 10 + k), 0, 0, 0, 0);
      if (k == SNOOZE_MIN * 60) begin
        chk("snooze_rering", on_alarm, 1);
        chk("snooze_rering_time", clock_time, 24'h073510);
        chk("snooze_rering_active", alarm_active, 1);
      end
    end
    step(24'h073510, 0, 0, 0, 1);
    chk("stop_active", alarm_active, 0);
    chk("stop_snoozing", snoozing, 0);

    // Reset in the middle of RING
    step(24'h072959, 0, 0, 0, 0);
    step(24'h073000, 0, 0, 0, 0);
    rst_n = 0;
    step(24'h073001, 0, 0, 0, 0);
    chk("rst_ring_active", alarm_active, 0);
    chk("rst_alarm_time", alarm_time, 0);
    rst_n = 1;
    step(24'h073001, 0, 0, 0, 0);

`ifdef ALARM_QUIET_HOURS_EN
    step(24'h073001, 1, 16'h2300, 0, 0);
    step(24'h225959, 0, 0, 0, 0);
    step(24'h230000, 0, 0, 0, 0);
    chk("quiet_alarm", on_alarm, 1);
    chk("quiet_hour", on_the_hour, 0);
    chk("quiet_chime", chime_count, 11);
`endif

    // Random run against the model
    cs = bcd2sec(24'h073001);
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] na;
      bit aset, snz, stp;
      r = $urandom_range(0, 99);
      if (r < 72) cs++;
      else if (r < 82) cs = cs;
      else if (r < 88) cs = bcd2sec({m_alarm, 8'h00}) - $urandom_range(0, 3);
      else if (r < 92) cs = (cs / 3600 + 1) * 3600 - 1;
      else if (r < 94) cs = $urandom_range(0, 86399);
      else cs++;
      cs = ((cs % 86400) + 86400) % 86400;
      aset = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 1) == 1) begin
        logic [23:0] t;
        t = sec2bcd(cs + $urandom_range(2, 90));
        na = t[23:8];
      end else na = 16'($urandom);
      snz = ($urandom_range(0, 99) < 3);
      stp = ($urandom_range(0, 99) < 1);
      alarm_en = ($urandom_range(0, 199) != 0);
      rst_n = ($urandom_range(0, 499) != 0);
      step(sec2bcd(cs), aset, na, snz, stp);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
